oled_dy_field_mux: RTL

Multi-channel dynamic numeric field renderer for the SSD1306 text path. It watches NUM_CH independent numeric values and, whenever one changes, converts it into DIGITS characters (decimal or hex, with optional leading-zero blanking). It then issues those characters one by one to the shared char_gen through the same start/busy/done handshake used by the fixed-text path. It sits between application logic and the top-level draw mux, and yields to fixed-text drawing via fix_active.

---
 rtl/oled_dy_field_mux.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/oled_dy_field_mux.sv
// oled_dy_field_mux
// Renders up to NUM_CH numeric fields onto the shared char_gen. Whenever a channel's value or
// hex flag differs from what was last drawn, that channel is granted round-robin. Its value is
// converted to DIGITS characters (decimal via double-dabble, or hex nibbles), and the characters
// are issued one at a time through the char_gen start/busy/done handshake.
//
// Ports:
//   clk_50m, rst_n        system clock, asynchronous active-low reset
//   ch_value/ch_x/ch_y    packed per-channel value, start column and row (channel 0 in LSBs)
//   ch_hex                per-channel hex rendering select
//   is_run, fix_active    gate new field grants only; a field in progress always completes
//   draw_busy, draw_done  char_gen handshake inputs
//   dy_active             block owns char_gen for the duration of a field
//   dy_draw_start         1-cycle start pulse, with registered ascii/x/y held until next start
//   dy_ch                 channel currently (or last) rendered
module oled_dy_field_mux #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned VAL_W    = 16,
  parameter int unsigned BLANK_LZ = 1,
  parameter int unsigned CHAR_ADV = 8
) (
  input  logic                    clk_50m,
  input  logic                    rst_n,
  input  logic [NUM_CH*VAL_W-1:0] ch_value,
  input  logic [NUM_CH*7-1:0]     ch_x,
  input  logic [NUM_CH*4-1:0]     ch_y,
  input  logic [NUM_CH-1:0]       ch_hex,
  input  logic                    is_run,
  input  logic                    fix_active,
  input  logic                    draw_busy,
  input  logic                    draw_done,
  output logic                    dy_active,
  output logic                    dy_draw_start,
  output logic [7:0]              dy_draw_ascii,
  output logic [6:0]              dy_draw_x,
  output logic [3:0]              dy_draw_y,
  output logic [1:0]              dy_ch
);

  localparam int unsigned BcdW    = 20;
  localparam logic [2:0]  LastIdx = 3'(DIGITS - 1);
  localparam logic [4:0]  LastBit = 5'(VAL_W - 1);

  typedef enum logic [1:0] {StIdle, StConv, StIssue, StWait} state_e;
  state_e r_state, w_state_nxt;

  logic [VAL_W-1:0]  r_last_seen [NUM_CH];
  logic [NUM_CH-1:0] r_last_hex;
  logic [1:0]        r_rr_ptr;
  logic [VAL_W-1:0]  r_val;
  logic [BcdW-1:0]   r_bcd;
  logic              r_hex;
  logic [6:0]        r_x;
  logic [3:0]        r_y;
  logic [2:0]        r_idx;
  logic [4:0]        r_bit_cnt;
  logic              r_active, r_start;
  logic [7:0]        r_ascii;
  logic [6:0]        r_dx;
  logic [3:0]        r_dy;
  logic [1:0]        r_ch;

  logic [NUM_CH-1:0] w_pending;
  logic              w_any, w_grant_ok, w_g_hex, w_hi_nz;
  logic [1:0]        w_grant;
  logic [VAL_W-1:0]  w_g_val;
  logic [6:0]        w_g_x, w_x_calc;
  logic [3:0]        w_g_y, w_digit;
  logic [BcdW-1:0]   w_bcd_adj, w_src;
  logic [2:0]        w_pos;
  logic [7:0]        w_char;

  // Round-robin search: first pass from rr_ptr upward, second pass covers the wrap.
  always_comb begin
    w_pending = '0;
    w_any     = 1'b0;
    w_grant   = '0;
    w_g_val   = '0;
    w_g_hex   = 1'b0;
    w_g_x     = '0;
    w_g_y     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_pending[c] = (ch_value[c*VAL_W +: VAL_W] != r_last_seen[c]) || (ch_hex[c] != r_last_hex[c]);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!w_any && w_pending[c] && c >= int'(r_rr_ptr)) begin
        w_any   = 1'b1;
        w_grant = 2'(c);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!w_any && w_pending[c]) begin
        w_any   = 1'b1;
        w_grant = 2'(c);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (2'(c) == w_grant) begin
        w_g_val = ch_value[c*VAL_W +: VAL_W];
        w_g_hex = ch_hex[c];
        w_g_x   = ch_x[c*7 +: 7];
        w_g_y   = ch_y[c*4 +: 4];
      end
    end
    w_grant_ok = (r_state == StIdle) && is_run && !fix_active && w_any;
  end

  // Double-dabble add-3 step applied before each shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < 5; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
    end
  end

  // Character for the current index; digit position counts down from the most significant shown.
  always_comb begin
    w_pos   = LastIdx - r_idx;
    w_src   = r_hex ? BcdW'(r_val) : r_bcd;
    w_digit = '0;
    w_hi_nz = 1'b0;
    for (int p = 0; p < 5; p++) begin
      if (3'(p) == w_pos) w_digit = w_src[p*4 +: 4];
      if (p < int'(DIGITS) && 3'(p) > w_pos && w_src[p*4 +: 4] != 4'd0) w_hi_nz = 1'b1;
    end
    if (BLANK_LZ != 0 && w_digit == 4'd0 && !w_hi_nz && r_idx != LastIdx) begin
      w_char = 8'h20;
    end else if (w_digit < 4'd10) begin
      w_char = 8'h30 + {4'd0, w_digit};
    end else begin
      w_char = 8'h37 + {4'd0, w_digit};
    end
    w_x_calc = r_x + 7'(32'(r_idx) * CHAR_ADV);
  end

  // State register
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_grant_ok) w_state_nxt = w_g_hex ? StIssue : StConv;
      StConv:  if (r_bit_cnt == LastBit) w_state_nxt = StIssue;
      StIssue: if (!draw_busy) w_state_nxt = StWait;
      StWait:  if (draw_done) w_state_nxt = (r_idx == LastIdx) ? StIdle : StIssue;
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) r_last_seen[c] <= '0;
      r_last_hex <= '0;
      r_rr_ptr   <= '0;
      r_val      <= '0;
      r_bcd      <= '0;
      r_hex      <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_idx      <= '0;
      r_bit_cnt  <= '0;
      r_active   <= 1'b0;
      r_start    <= 1'b0;
      r_ascii    <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_ch       <= '0;
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_grant_ok) begin
            for (int c = 0; c < NUM_CH; c++) begin
              if (2'(c) == w_grant) begin
                r_last_seen[c] <= w_g_val;
                r_last_hex[c]  <= w_g_hex;
              end
            end
            r_val     <= w_g_val;
            r_hex     <= w_g_hex;
            r_x       <= w_g_x;
            r_y       <= w_g_y;
            r_ch      <= w_grant;
            r_active  <= 1'b1;
            r_idx     <= '0;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
          end
        end
        StConv: begin
          r_bcd     <= {w_bcd_adj[BcdW-2:0], r_val[VAL_W-1]};
          r_val     <= {r_val[VAL_W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
        StIssue: begin
          if (!draw_busy) begin
            r_start <= 1'b1;
            r_ascii <= w_char;
            r_dx    <= w_x_calc;
            r_dy    <= r_y;
          end
        end
        StWait: begin
          if (draw_done) begin
            if (r_idx == LastIdx) begin
              r_active <= 1'b0;
              r_rr_ptr <= (r_ch == 2'(NUM_CH - 1)) ? 2'd0 : r_ch + 2'd1;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
      endcase
    end
  end

  assign dy_active     = r_active;
  assign dy_draw_start = r_start;
  assign dy_draw_ascii = r_ascii;
  assign dy_draw_x     = r_dx;
  assign dy_draw_y     = r_dy;
  assign dy_ch         = r_ch;

endmodule
